// File: rtl/t_ff_mod_counter_pkg.sv
// Shared definitions for the T flip-flop modulo counter: direction encodings
// and the saturating load clamp.
package tff_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam int unsigned CLAMP_W = 32;

  // Out-of-range load values saturate to the top of the count range.
  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] val,
                                                    input logic [CLAMP_W-1:0] mod);
    logic [CLAMP_W-1:0] res;
    if (val < mod) begin
      res = val;
    end else begin
      res = mod - 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/t_ff_mod_counter_cell.sv
// Single T flip-flop cell with synchronous active-high reset to a
// per-cell reset value.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q,
  output logic q_bar
);

  logic q_d;
  logic q_q;

  // Toggle when t is set, otherwise hold.
  always_comb begin
    q_d = q_q ^ t;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/t_ff_mod_counter.sv
// Modulo up/down counter with load and terminal count, built from WIDTH
// T flip-flop cells driven by the toggle vector q ^ q_next.
module t_ff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 32'sd1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(32'd1);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH)) || (RESET_VAL >= MODULUS) ||
      (RESET_VAL < 0)) begin : g_bad_params
    $error("t_ff_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] toggle_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic             tc_s;
  logic             wrap_d;
  logic             wrap_q;

  assign load_clamp_s = WIDTH'(clamp_load(CLAMP_W'(load_val), CLAMP_W'(MODULUS)));

  // Next count value and the per-cell toggle vector that produces it.
  always_comb begin
    next_s = q_s;
    if (load) begin
      next_s = load_clamp_s;
    end else if (en) begin
      if (up_dn == UP) begin
        if (q_s == MAX_VAL) begin
          next_s = ZERO;
        end else begin
          next_s = q_s + ONE;
        end
      end else begin
        if (q_s == ZERO) begin
          next_s = MAX_VAL;
        end else begin
          next_s = q_s - ONE;
        end
      end
    end else begin
      next_s = q_s;
    end
    toggle_s = q_s ^ next_s;
  end

  // Terminal count on the current state; a wrap is recorded only when counting.
  always_comb begin
    tc_s   = en & (((up_dn == UP) & (q_s == MAX_VAL)) |
                   ((up_dn == DOWN) & (q_s == ZERO)));
    wrap_d = tc_s & ~load;
  end

  // Wrap pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    t_ff_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .rst_val(RST_VAL[i]),
      .t      (toggle_s[i]),
      .q      (q_s[i]),
      .q_bar  (q_bar[i])
    );
  end

  assign q    = q_s;
  assign tc   = tc_s;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// Self-checking bench for t_ff_mod_counter (WIDTH=4, MODULUS=10, RESET_VAL=0):
// directed vector table, hand-written corner sequences, random stimulus vs model.
module tb_t_ff_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
  localparam int RV  = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         tc;
  logic         wrap;

  always #5 clk = ~clk;

  t_ff_mod_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .q_bar   (q_bar),
    .tc      (tc),
    .wrap    (wrap)
  );

  int errors = 0;
  int checks = 0;
  int m_q    = -1;
  bit m_wrap = 1'b0;

  typedef struct {
    bit r; bit l; bit e; bit u; int lv;
    int eq; bit ew; bit etc;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, check tc before the edge, then q/q_bar/wrap after.
  task automatic apply(input bit r, input bit l, input bit e, input bit u, input int lv,
                       output bit tc_seen);
    int nq;
    @(negedge clk);
    rst = r; load = l; en = e; up_dn = u; load_val = lv[W-1:0];
    #1;
    tc_seen = tc;
    if (m_q >= 0) chk("tc_model", {31'd0, tc}, {31'd0, e && (u ? (m_q == MOD-1) : (m_q == 0))});
    @(posedge clk);
    if (r)      nq = RV;
    else if (l) nq = (lv < MOD) ? lv : MOD - 1;
    else if (e) nq = (m_q + (u ? 1 : MOD - 1)) % MOD;
    else        nq = m_q;
    m_wrap = !r && !l && e && (u ? (nq < m_q) : (nq > m_q));
    m_q = nq;
    #1;
    chk("q_model", {28'd0, q}, m_q);
    chk("q_bar", {28'd0, q_bar}, {28'd0, ~m_q[W-1:0]});
    chk("wrap_model", {31'd0, wrap}, {31'd0, m_wrap});
  endtask

  initial begin
    bit t;

    // Reset and hold
    vt.push_back('{1,0,0,1,0, 0,0,0});
    vt.push_back('{0,0,0,1,0, 0,0,0});
    vt.push_back('{0,0,0,1,0, 0,0,0});
    vt.push_back('{0,0,0,1,0, 0,0,0});
    // Up count 12 edges
    for (int i = 1; i <= 12; i++)
      vt.push_back('{0,0,1,1,0, i % MOD, (i == 10), (i == 10)});
    // Down count from 2
    vt.push_back('{0,0,1,0,0, 1,0,0});
    vt.push_back('{0,0,1,0,0, 0,0,0});
    vt.push_back('{0,0,1,0,0, 9,1,1});
    vt.push_back('{0,0,1,0,0, 8,0,0});
    // Load, clamp, load beats count
    vt.push_back('{0,1,0,1,7,  7,0,0});
    vt.push_back('{0,1,0,1,13, 9,0,0});
    vt.push_back('{0,1,1,1,9,  9,0,1});

    apply(1'b1, 1'b0, 1'b0, 1'b1, 0, t);
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].r, vt[i].l, vt[i].e, vt[i].u, vt[i].lv, t);
      chk($sformatf("tbl_tc[%0d]", i), {31'd0, t}, {31'd0, vt[i].etc});
      chk($sformatf("tbl_q[%0d]", i), {28'd0, q}, vt[i].eq);
      chk($sformatf("tbl_wrap[%0d]", i), {31'd0, wrap}, {31'd0, vt[i].ew});
    end

    // Reset mid-count overrides load
    apply(1'b0, 1'b1, 1'b0, 1'b1, 4, t);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 0, t);
    chk("mid_q5", {28'd0, q}, 5);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 3, t);
    chk("rst_q", {28'd0, q}, 0);
    chk("rst_wrap", {31'd0, wrap}, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 0, t);
    chk("resume_q", {28'd0, q}, 1);

    // Reset while tc is high: no wrap pulse
    apply(1'b0, 1'b1, 1'b0, 1'b1, 9, t);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 0, t);
    chk("rst_tc_pre", {31'd0, t}, 1);
    chk("rst_tc_wrap", {31'd0, wrap}, 0);

    // Direction flip at the boundary, tc follows up_dn in the same cycle
    apply(1'b0, 1'b1, 1'b0, 1'b1, 9, t);
    en = 1'b1; up_dn = 1'b0;
    #1 chk("flip_tc_dn", {31'd0, tc}, 0);
    up_dn = 1'b1;
    #1 chk("flip_tc_up", {31'd0, tc}, 1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 0, t);
    chk("flip_q0", {28'd0, q}, 0);
    chk("flip_w0", {31'd0, wrap}, 1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 0, t);
    chk("flip_tc0", {31'd0, t}, 1);
    chk("flip_q9", {28'd0, q}, 9);
    chk("flip_w9", {31'd0, wrap}, 1);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
